// File: rtl/rate_tick_gen.sv
// Purpose: divide the board clock to a selectable rate and emit a one-cycle clock-enable tick.
// Latency: tick and count are registered; tick rises one cycle after the expiry edge.
// Backpressure: none; enable=0 freezes the period and forces tick low.
//
// Ports:
//   clock     - system clock, all state updates on the rising edge
//   clear_n   - synchronous active-low reset, wins over every other input
//   enable    - 1 = run, 0 = pause (count held, tick low)
//   speed_sel - 00 every cycle, 01 = CLK_HZ, 10 = 2*CLK_HZ, 11 = 4*CLK_HZ cycles per tick
//   tick      - registered one-cycle enable pulse for the downstream counter
//   count     - current down-counter value, exposed for debug
module rate_tick_gen #(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned WIDTH  = 28
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             enable,
  input  logic [1:0]       speed_sel,
  output logic             tick,
  output logic [WIDTH-1:0] count
);

  // Reload values are D-1, formed at full WIDTH so the 4x divisor is never truncated.
  localparam logic [WIDTH-1:0] RELOAD_1HZ  = WIDTH'(CLK_HZ - 1);
  localparam logic [WIDTH-1:0] RELOAD_HALF = WIDTH'(2 * CLK_HZ - 1);
  localparam logic [WIDTH-1:0] RELOAD_QTR  = WIDTH'(4 * CLK_HZ - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] reload;

  // Reload for the currently presented select; used by reset, rate change and expiry.
  always_comb begin
    reload = '0;
    case (speed_sel)
      2'b00:   reload = '0;
      2'b01:   reload = RELOAD_1HZ;
      2'b10:   reload = RELOAD_HALF;
      default: reload = RELOAD_QTR;
    endcase
  end

  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    sel_d   = sel_q;
    if (speed_sel != sel_q) begin
      // A rate change restarts the period immediately; an expiry landing on
      // this edge is dropped so the new rate starts from a clean full period.
      count_d = reload;
      sel_d   = speed_sel;
    end else if (!enable) begin
      count_d = count_q;
    end else if (count_q == '0) begin
      count_d = reload;
      tick_d  = 1'b1;
    end else begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      count_q <= reload;
      tick_q  <= 1'b0;
      sel_q   <= speed_sel;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
      sel_q   <= sel_d;
    end
  end

  assign tick  = tick_q;
  assign count = count_q;

endmodule

// File: tb/tb_rate_tick_gen.sv
// Purpose: directed, table-driven check of rate_tick_gen at CLK_HZ=4 (D = 1/4/8/16).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; the bench drives every input each cycle.
module tb_rate_tick_gen;

  localparam int unsigned CLK_HZ = 4;
  localparam int unsigned WIDTH  = 28;

  logic             clock;
  logic             clear_n;
  logic             enable;
  logic [1:0]       speed_sel;
  logic             tick;
  logic [WIDTH-1:0] count;

  int n_checks = 0;
  int n_pass   = 0;

  rate_tick_gen #(.CLK_HZ(CLK_HZ), .WIDTH(WIDTH)) dut (
    .clock     (clock),
    .clear_n   (clear_n),
    .enable    (enable),
    .speed_sel (speed_sel),
    .tick      (tick),
    .count     (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic             cn;
    logic             en;
    logic [1:0]       sel;
    logic             exp_tick;
    logic [WIDTH-1:0] exp_count;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic cn, input logic en, input logic [1:0] sel,
                              input logic et, input int unsigned ec);
    vec_t v;
    v.cn        = cn;
    v.en        = en;
    v.sel       = sel;
    v.exp_tick  = et;
    v.exp_count = WIDTH'(ec);
    tbl.push_back(v);
  endfunction

  // Drive inputs, take one rising edge, then compare both outputs.
  task automatic step(input logic cn, input logic en, input logic [1:0] sel,
                      input logic et, input logic [WIDTH-1:0] ec, input string nm);
    clear_n   = cn;
    enable    = en;
    speed_sel = sel;
    @(posedge clock);
    #1;
    n_checks++;
    if (tick === et) n_pass++;
    else $display("FAIL %s tick: got %0b expected %0b", nm, tick, et);
    n_checks++;
    if (count === ec) n_pass++;
    else $display("FAIL %s count: got %0d expected %0d", nm, count, ec);
  endtask

  initial begin
    clear_n   = 1'b0;
    enable    = 1'b1;
    speed_sel = 2'b01;

    // Reset with sel=01, then run: ticks after edges 4, 8, 12 past reset.
    add(0, 1, 2'b01, 0, 3);
    add(0, 1, 2'b01, 0, 3);
    for (int k = 1; k <= 12; k++)
      add(1, 1, 2'b01, (k % 4 == 0), (k % 4 == 0) ? 3 : 3 - (k % 4));
    // Switch to every-cycle rate: change edge gives no tick, then tick every cycle.
    add(1, 1, 2'b00, 0, 0);
    for (int k = 0; k < 5; k++) add(1, 1, 2'b00, 1, 0);
    // Pause at R=0 forces tick low.
    add(1, 0, 2'b00, 0, 0);
    add(1, 1, 2'b00, 1, 0);

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].cn, tbl[i].en, tbl[i].sel, tbl[i].exp_tick, tbl[i].exp_count,
           $sformatf("tbl[%0d]", i));

    // sel=11: period 16, count 15..0 then reload.
    step(1, 1, 2'b11, 0, 15, "sel11_change");
    for (int j = 1; j <= 32; j++)
      step(1, 1, 2'b11, (j % 16 == 0), WIDTH'(15 - (j % 16)), $sformatf("sel11_e%0d", j));

    // sel=10 pause/resume: hold at 5 for 10 cycles, tick exactly 6 enabled edges later.
    step(1, 1, 2'b10, 0, 7, "pause_change");
    step(1, 1, 2'b10, 0, 6, "pause_run6");
    step(1, 1, 2'b10, 0, 5, "pause_run5");
    for (int j = 0; j < 10; j++) step(1, 0, 2'b10, 0, 5, $sformatf("pause_hold%0d", j));
    for (int j = 4; j >= 0; j--) step(1, 1, 2'b10, 0, WIDTH'(j), $sformatf("resume_c%0d", j));
    step(1, 1, 2'b10, 1, 7, "resume_tick");

    // Enable dropped on the would-be expiry edge: no tick, count stays 0.
    for (int j = 6; j >= 0; j--) step(1, 1, 2'b10, 0, WIDTH'(j), $sformatf("exp_c%0d", j));
    step(1, 0, 2'b10, 0, 0, "exp_paused0");
    step(1, 0, 2'b10, 0, 0, "exp_paused1");
    step(1, 1, 2'b10, 1, 7, "exp_resume_tick");

    // Rate change 11 -> 01 mid-period at count 7.
    step(1, 1, 2'b11, 0, 15, "rc_to11");
    for (int j = 14; j >= 7; j--) step(1, 1, 2'b11, 0, WIDTH'(j), $sformatf("rc_c%0d", j));
    step(1, 1, 2'b01, 0, 3, "rc_to01");
    for (int k = 1; k <= 8; k++)
      step(1, 1, 2'b01, (k % 4 == 0), WIDTH'((k % 4 == 0) ? 3 : 3 - (k % 4)),
           $sformatf("rc01_e%0d", k));
    // Rate change on a pending expiry edge drops the tick.
    step(1, 1, 2'b01, 0, 2, "rcx_c2");
    step(1, 1, 2'b01, 0, 1, "rcx_c1");
    step(1, 1, 2'b01, 0, 0, "rcx_c0");
    step(1, 1, 2'b10, 0, 7, "rcx_dropped");

    // Reset on the expiry edge: no tick, full reload, next tick a full period later.
    for (int j = 6; j >= 0; j--) step(1, 1, 2'b10, 0, WIDTH'(j), $sformatf("rst_c%0d", j));
    step(0, 1, 2'b10, 0, 7, "rst_on_expiry");
    for (int j = 6; j >= 0; j--) step(1, 1, 2'b10, 0, WIDTH'(j), $sformatf("rst_after_c%0d", j));
    step(1, 1, 2'b10, 1, 7, "rst_after_tick");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
